// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio echo stage: default sample width,
// FSM state encoding and the saturating adder used by the mix datapath.
package audio_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int SAT_W          = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_SEND
  } echo_state_e;

  // Operands arrive sign-extended to SAT_W; result is clamped to a signed
  // range of 'width' bits (width must stay well below SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      sat_add = max_v;
    end else if (sum < min_v) begin
      sat_add = min_v;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/audio_echo_stage_if.sv
// Codec-side stream handshake: input pair with read strobe, output pair
// with write strobe. The codec is the master, the echo stage the slave.
interface audio_codec_if
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic                     audio_in_available;
  logic                     read_audio_in;
  logic signed [DATA_W-1:0] audio_in_L;
  logic signed [DATA_W-1:0] audio_in_R;
  logic                     audio_out_allowed;
  logic                     write_audio_out;
  logic signed [DATA_W-1:0] audio_out_L;
  logic signed [DATA_W-1:0] audio_out_R;

  modport master (
    output audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
    input  read_audio_in, write_audio_out, audio_out_L, audio_out_R
  );

  modport slave (
    input  audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
    output read_audio_in, write_audio_out, audio_out_L, audio_out_R
  );

endinterface

// File: rtl/audio_echo_stage_ram.sv
// Simple dual-port delay buffer holding {left, right} output pairs.
// Registered read, no reset; stale contents are masked by the fill count.
module echo_delay_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/audio_echo_stage.sv
// Echo stage: takes one codec sample pair per FSM pass and mixes in an
// attenuated copy of the output from D samples earlier, with saturation.
module audio_echo_stage
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  audio_codec_if.slave codec,
  input  logic         echo_en,
  input  logic [3:0]   delay_sel,
  input  logic [1:0]   atten_sel
);

  localparam int               CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << DEPTH_LOG2;

  echo_state_e              state_q, state_d;
  logic signed [DATA_W-1:0] x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [DATA_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic                     echo_en_q, echo_en_d;
  logic [3:0]               delay_sel_q, delay_sel_d;
  logic [1:0]               atten_sel_q, atten_sel_d;
  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;

  logic [CNT_W-1:0]         delay_len;
  logic [DEPTH_LOG2-1:0]    rd_addr;
  logic [2:0]               shamt;
  logic                     ram_re, ram_we;
  logic [2*DATA_W-1:0]      ram_rdata;
  logic signed [DATA_W-1:0] echo_l, echo_r, echo_sh_l, echo_sh_r, y_l, y_r;
  logic                     read_pulse, write_pulse;

  assign delay_len = (CNT_W'(delay_sel_q) + CNT_W'(1)) << (DEPTH_LOG2 - 4);
  assign rd_addr   = wr_ptr_q - delay_len[DEPTH_LOG2-1:0];
  assign shamt     = {1'b0, atten_sel_q} + 3'd1;

  // Until D outputs have been written, the slot at rd_addr is stale.
  always_comb begin
    echo_l = '0;
    echo_r = '0;
    if (echo_en_q && (fill_cnt_q >= delay_len)) begin
      echo_l = $signed(ram_rdata[2*DATA_W-1:DATA_W]);
      echo_r = $signed(ram_rdata[DATA_W-1:0]);
    end
    echo_sh_l = echo_l >>> shamt;
    echo_sh_r = echo_r >>> shamt;
    y_l = DATA_W'(sat_add(SAT_W'(x_l_q), SAT_W'(echo_sh_l), DATA_W));
    y_r = DATA_W'(sat_add(SAT_W'(x_r_q), SAT_W'(echo_sh_r), DATA_W));
  end

  always_comb begin
    state_d     = state_q;
    x_l_d       = x_l_q;
    x_r_d       = x_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    echo_en_d   = echo_en_q;
    delay_sel_d = delay_sel_q;
    atten_sel_d = atten_sel_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    read_pulse  = 1'b0;
    write_pulse = 1'b0;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reset_n && codec.audio_in_available && codec.audio_out_allowed) begin
          read_pulse  = 1'b1;
          x_l_d       = codec.audio_in_L;
          x_r_d       = codec.audio_in_R;
          echo_en_d   = echo_en;
          delay_sel_d = delay_sel;
          atten_sel_d = atten_sel;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_CALC;
      end
      // Outputs are loaded here so they are already valid during the write strobe.
      ST_CALC: begin
        out_l_d = y_l;
        out_r_d = y_r;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (codec.audio_out_allowed) begin
          write_pulse = 1'b1;
          ram_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          fill_cnt_d  = (fill_cnt_q == DEPTH) ? fill_cnt_q : fill_cnt_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_l_q       <= '0;
      x_r_q       <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      echo_en_q   <= 1'b0;
      delay_sel_q <= '0;
      atten_sel_q <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_l_q       <= x_l_d;
      x_r_q       <= x_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      echo_en_q   <= echo_en_d;
      delay_sel_q <= delay_sel_d;
      atten_sel_q <= atten_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  echo_delay_ram #(
    .WIDTH  (2*DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({out_l_q, out_r_q}),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign codec.read_audio_in   = read_pulse;
  assign codec.write_audio_out = write_pulse;
  assign codec.audio_out_L     = out_l_q;
  assign codec.audio_out_R     = out_r_q;

endmodule

// File: tb/tb_audio_echo_stage.sv
// Directed bench for audio_echo_stage with a 16-deep delay buffer:
// passthrough, echo decay, saturation, backpressure, mid-transfer reset, wrap.
module tb_audio_echo_stage;

  logic       CLOCK_50;
  logic       reset_n;
  logic       echo_en;
  logic [3:0] delay_sel;
  logic [1:0] atten_sel;
  int         checks;
  int         errors;

  localparam logic signed [31:0] S_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] S_MIN = 32'sh8000_0000;

  audio_codec_if #(.DATA_W(32)) cif ();

  audio_echo_stage #(
    .DATA_W     (32),
    .DEPTH_LOG2 (4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .codec     (cif),
    .echo_en   (echo_en),
    .delay_sel (delay_sel),
    .atten_sel (atten_sel)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge CLOCK_50);
    reset_n                = 1'b0;
    cif.audio_in_available = 1'b1;
    cif.audio_out_allowed  = 1'b1;
    #1;
    checkOutput({tag, "_read"},  cif.read_audio_in,   0);
    checkOutput({tag, "_write"}, cif.write_audio_out, 0);
    checkOutput({tag, "_out_l"}, cif.audio_out_L,     0);
    checkOutput({tag, "_out_r"}, cif.audio_out_R,     0);
    @(negedge CLOCK_50);
    cif.audio_in_available = 1'b0;
    reset_n                = 1'b1;
    @(negedge CLOCK_50);
  endtask

  // One full transfer; optionally disturbs inputs and controls after the read.
  task automatic applyStimulus(input string tag,
                               input logic signed [31:0] in_l, input logic signed [31:0] in_r,
                               input logic signed [31:0] exp_l, input logic signed [31:0] exp_r,
                               input bit scramble);
    int         n;
    logic       sv_en;
    logic [3:0] sv_delay;
    logic [1:0] sv_atten;
    sv_en    = echo_en;
    sv_delay = delay_sel;
    sv_atten = atten_sel;
    cif.audio_in_L         = in_l;
    cif.audio_in_R         = in_r;
    cif.audio_in_available = 1'b1;
    cif.audio_out_allowed  = 1'b1;
    #1;
    n = 0;
    while (!cif.read_audio_in && n < 20) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    checkOutput({tag, "_read"},     cif.read_audio_in,   1);
    checkOutput({tag, "_rd_excl"},  cif.write_audio_out, 0);
    @(negedge CLOCK_50);
    cif.audio_in_available = 1'b0;
    cif.audio_in_L         = 32'sd12345;
    cif.audio_in_R         = -32'sd12345;
    if (scramble) begin
      echo_en   = ~echo_en;
      delay_sel = ~delay_sel;
      atten_sel = ~atten_sel;
    end
    #1;
    n = 1;
    while (!cif.write_audio_out && n < 20) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"},  n,                 3);
    checkOutput({tag, "_out_l"},    cif.audio_out_L,   exp_l);
    checkOutput({tag, "_out_r"},    cif.audio_out_R,   exp_r);
    checkOutput({tag, "_wr_excl"},  cif.read_audio_in, 0);
    @(negedge CLOCK_50);
    #1;
    checkOutput({tag, "_single"},   cif.write_audio_out, 0);
    checkOutput({tag, "_hold_l"},   cif.audio_out_L,     exp_l);
    echo_en   = sv_en;
    delay_sel = sv_delay;
    atten_sel = sv_atten;
  endtask

  initial begin
    logic signed [31:0] in_l, in_r, exp_l, exp_r;
    logic signed [31:0] wrap_l [40];
    logic signed [31:0] wrap_r [40];
    logic               stall_write, stall_read;
    checks = 0;
    errors = 0;
    reset_n   = 1'b1;
    echo_en   = 1'b0;
    delay_sel = 4'd0;
    atten_sel = 2'd0;
    cif.audio_in_available = 1'b0;
    cif.audio_out_allowed  = 1'b0;
    cif.audio_in_L         = '0;
    cif.audio_in_R         = '0;

    // Passthrough: second transfer is primed, so echo_en=0 must still mask it.
    doReset("rst0");
    applyStimulus("pass0", 1000, -1000, 1000, -1000, 1'b0);
    applyStimulus("pass1", 2000, -2000, 2000, -2000, 1'b0);

    // Echo decay with D=1 and various gains, including negative floor shifts.
    doReset("rst1");
    echo_en = 1'b1; delay_sel = 4'd0; atten_sel = 2'd0;
    applyStimulus("echo0", 1000, 2000, 1000, 2000, 1'b0);
    applyStimulus("echo1", 0, 0, 500, 1000, 1'b0);
    applyStimulus("echo2", 0, 0, 250, 500, 1'b1);
    applyStimulus("echo3", 0, 0, 125, 250, 1'b0);
    atten_sel = 2'd1;
    applyStimulus("att1", 0, 0, 31, 62, 1'b0);
    atten_sel = 2'd0;
    applyStimulus("neg0", -100, -101, -85, -70, 1'b0);
    applyStimulus("neg1", 0, 0, -43, -35, 1'b0);
    atten_sel = 2'd3;
    applyStimulus("att3", 0, 0, -3, -3, 1'b0);

    // Saturation at both rails.
    doReset("rst2");
    echo_en = 1'b1; delay_sel = 4'd0; atten_sel = 2'd0;
    applyStimulus("sat0", S_MAX, S_MIN, S_MAX, S_MIN, 1'b0);
    applyStimulus("sat1", S_MAX, S_MIN, S_MAX, S_MIN, 1'b0);

    // Backpressure: output side blocked from FETCH for 10 cycles.
    doReset("rst3");
    echo_en = 1'b0;
    cif.audio_in_L = 32'sd5;
    cif.audio_in_R = -32'sd5;
    cif.audio_in_available = 1'b1;
    cif.audio_out_allowed  = 1'b1;
    #1;
    checkOutput("bp_read", cif.read_audio_in, 1);
    @(negedge CLOCK_50);
    cif.audio_out_allowed = 1'b0;
    stall_write = 1'b0;
    stall_read  = 1'b0;
    repeat (10) begin
      @(negedge CLOCK_50);
      #1;
      stall_write |= cif.write_audio_out;
      stall_read  |= cif.read_audio_in;
    end
    checkOutput("bp_no_write", stall_write, 0);
    checkOutput("bp_no_read",  stall_read,  0);
    cif.audio_out_allowed = 1'b1;
    #1;
    checkOutput("bp_write", cif.write_audio_out, 1);
    checkOutput("bp_out_l", cif.audio_out_L, 5);
    checkOutput("bp_out_r", cif.audio_out_R, -5);
    checkOutput("bp_excl",  cif.read_audio_in, 0);
    cif.audio_in_available = 1'b0;
    @(negedge CLOCK_50);
    #1;
    checkOutput("bp_single", cif.write_audio_out, 0);
    checkOutput("bp_no_2nd_read", cif.read_audio_in, 0);

    // Primed transfer, then a transfer aborted by reset while in CALC.
    echo_en = 1'b1; delay_sel = 4'd0; atten_sel = 2'd0;
    applyStimulus("pre", 300, 300, 302, 297, 1'b0);
    cif.audio_in_L = '0;
    cif.audio_in_R = '0;
    cif.audio_in_available = 1'b1;
    #1;
    checkOutput("abort_read", cif.read_audio_in, 1);
    @(negedge CLOCK_50);
    cif.audio_in_available = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_write", cif.write_audio_out, 0);
    checkOutput("abort_out_l", cif.audio_out_L, 0);
    checkOutput("abort_out_r", cif.audio_out_R, 0);
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    #1;
    checkOutput("abort_no_late_write", cif.write_audio_out, 0);
    delay_sel = 4'd15;
    applyStimulus("unprimed", 7, 7, 7, 7, 1'b0);

    // Ramp through two pointer wraps with D=16.
    doReset("rst4");
    echo_en = 1'b1; delay_sel = 4'd15; atten_sel = 2'd0;
    for (int k = 0; k < 40; k++) begin
      in_l  = k * 100 + 1;
      in_r  = -(k * 64) - 3;
      exp_l = in_l;
      exp_r = in_r;
      if (k >= 16) begin
        exp_l += wrap_l[k-16] >>> 1;
        exp_r += wrap_r[k-16] >>> 1;
      end
      wrap_l[k] = exp_l;
      wrap_r[k] = exp_r;
      applyStimulus($sformatf("wrap%0d", k), in_l, in_r, exp_l, exp_r, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_echo_stage.md
AUDIO_ECHO_STAGE -- requirements
Module: audio_echo_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample width in bits (signed, two's complement).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of delay-buffer depth in stereo samples.
REQ-003 SHALL have port CLOCK_50  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port audio_in_available  input  1  codec has an input sample pair ready.
REQ-006 SHALL have port read_audio_in  output  1  one-cycle pulse consuming the input pair.
REQ-007 SHALL have port audio_in_L / audio_in_R  input  DATA_W each  signed input samples.
REQ-008 SHALL have port audio_out_allowed  input  1  codec can accept an output pair.
REQ-009 SHALL have port write_audio_out  output  1  one-cycle pulse delivering the output pair.
REQ-010 SHALL have port audio_out_L / audio_out_R  output  DATA_W each  signed output samples, registered.
REQ-011 SHALL have port echo_en  input  1  1 = echo mixed in; 0 = passthrough.
REQ-012 SHALL have port delay_sel  input  4  delay D = (delay_sel+1) * 2^(DEPTH_LOG2-4) samples.
REQ-013 SHALL have port atten_sel  input  2  echo gain = 2^-(atten_sel+1).

Function
REQ-014 SHALL run FSM IDLE -> FETCH -> CALC -> SEND -> IDLE, one transfer at a time.
REQ-015 IDLE: when audio_in_available && audio_out_allowed, SHALL assert read_audio_in that cycle, latch audio_in_L/R, sample delay_sel/atten_sel/echo_en, go FETCH; otherwise stay.
REQ-016 FETCH SHALL issue the buffer read at rd_addr = (wr_ptr - D) mod 2^DEPTH_LOG2; CALC SHALL capture the registered read data.
REQ-017 CALC SHALL compute per channel y = sat(x + (d >>> (atten_sel+1))), sum in DATA_W+1 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], arithmetic shift.
REQ-018 d SHALL be forced to 0 when echo_en=0 or fill_cnt < D (buffer not yet primed).
REQ-019 SEND SHALL wait for audio_out_allowed, then assert write_audio_out for exactly one cycle with audio_out_L/R = y, write {yL,yR} to buffer at wr_ptr, increment wr_ptr (wraps at 2^DEPTH_LOG2), increment fill_cnt (saturates at 2^DEPTH_LOG2), go IDLE.
REQ-020 Latency: write_audio_out SHALL pulse no earlier than 3 cycles after read_audio_in (exactly 3 if audio_out_allowed stays high).
REQ-021 read_audio_in and write_audio_out SHALL never be high in the same cycle; at most one read per write.
REQ-022 audio_out_L/R SHALL hold their last value between writes.
REQ-023 Control inputs changing mid-transfer SHALL not affect the transfer in flight.

Reset
REQ-024 reset_n low SHALL force state IDLE, read_audio_in=0, write_audio_out=0, audio_out_L/R=0, wr_ptr=0, fill_cnt=0, asynchronously.
REQ-025 Buffer RAM contents SHALL not be reset; fill_cnt gating (REQ-018) masks stale data.
REQ-026 Reset asserted mid-transfer SHALL abort it with no write pulse; first transfer after release starts from IDLE.

Structure
REQ-027 Package audio_pkg SHALL hold DATA_W default, FSM state enum, and the saturating-add function.
REQ-028 Buffer SHALL be sub-module echo_delay_ram: simple dual-port, 2*DATA_W wide, 2^DEPTH_LOG2 deep, one-cycle registered read, no reset.

Verification
REQ-029 Passthrough: echo_en=0, in 1000/-1000 -> out 1000/-1000, write_audio_out 3 cycles after read_audio_in.
REQ-030 Echo: DEPTH_LOG2=4, delay_sel=0 (D=1), atten_sel=0, inputs 1000 then 0 -> outputs 1000 then 500, then 250.
REQ-031 Saturation: echo primed with 2^31-1, atten_sel=0, next input 2^31-1 -> out 2^31-1; negative case -> -2^31.
REQ-032 Backpressure: audio_out_allowed dropped in FETCH for 10 cycles -> write_audio_out held off, single pulse when re-raised, no second read.
REQ-033 Wrap: DEPTH_LOG2=4, delay_sel=15 (D=16), 40 ramp samples -> output k = in k + in'(k-16)/2, correct across wr_ptr wrap.
REQ-034 Reset mid-transfer in CALC -> no write pulse, outputs 0, next transfer behaves as unprimed (d=0).
